// File: rtl/mii_frame_gen.sv
// MII/GMII receive-side frame generator: preamble, SFD, incrementing
// payload, CRC-32 FCS and inter-frame gap driven toward a MAC.
module mii_frame_gen #(
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned IFG_LEN      = 12
) (
  input  logic        Rx_clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  input  logic [15:0] frm_len,
  input  logic [7:0]  seed,
  input  logic        err_en,
  input  logic [15:0] err_pos,
  input  logic        fcs_bad,
  output logic        Rx_dv,
  output logic        Rx_er,
  output logic [7:0]  Rxd,
  output logic        busy,
  output logic        done,
  output logic [15:0] frm_cnt
);

  localparam logic [31:0] POLY     = 32'hEDB88320;
  localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);
  localparam logic [15:0] IFG_END  = 16'(IFG_LEN);

  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, FCS, IFG} state_t;

  state_t      state;
  logic [15:0] cnt;
  logic        phase;
  logic        mode_q;
  logic [15:0] len_q;
  logic [7:0]  seed_q;
  logic        err_en_q;
  logic [15:0] err_pos_q;
  logic        fcs_bad_q;
  logic [31:0] crc;

  logic        advance;
  logic        next_phase;
  logic [7:0]  data_byte;
  logic [31:0] fcs;
  logic [7:0]  cur_byte;
  logic [7:0]  lane;

  // One reflected CRC-32 byte update, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int unsigned i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    end
    return r;
  endfunction

  // Byte currently being sent and the lane value it maps to for this clock.
  always_comb begin
    advance    = mode_q | phase;
    next_phase = mode_q ? 1'b0 : ~phase;
    data_byte  = seed_q + cnt[7:0];
    fcs        = ~crc;
    cur_byte   = '0;
    case (state)
      PRE:  cur_byte = 8'h55;
      SFD:  cur_byte = 8'hD5;
      DATA: cur_byte = data_byte;
      FCS: begin
        case (cnt[1:0])
          2'd0:    cur_byte = fcs[7:0] ^ {7'b0, fcs_bad_q};
          2'd1:    cur_byte = fcs[15:8];
          2'd2:    cur_byte = fcs[23:16];
          default: cur_byte = fcs[31:24];
        endcase
      end
      default: cur_byte = '0;
    endcase
    if (mode_q) lane = cur_byte;
    else        lane = phase ? {4'h0, cur_byte[7:4]} : {4'h0, cur_byte[3:0]};
  end

  // Frame sequencer; the state names the byte to be driven on the next edge.
  // IFG counts IFG_LEN byte times, then one further edge raises done.
  always_ff @(posedge Rx_clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      phase     <= 1'b0;
      mode_q    <= 1'b0;
      len_q     <= 16'd1;
      seed_q    <= '0;
      err_en_q  <= 1'b0;
      err_pos_q <= '0;
      fcs_bad_q <= 1'b0;
      crc       <= '1;
      Rx_dv     <= 1'b0;
      Rx_er     <= 1'b0;
      Rxd       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frm_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          Rx_dv <= 1'b0;
          Rx_er <= 1'b0;
          Rxd   <= '0;
          phase <= 1'b0;
          cnt   <= '0;
          if (start) begin
            mode_q    <= mode;
            len_q     <= (frm_len == '0) ? 16'd1 : frm_len;
            seed_q    <= seed;
            err_en_q  <= err_en;
            err_pos_q <= err_pos;
            fcs_bad_q <= fcs_bad;
            busy      <= 1'b1;
            state     <= PRE;
          end
        end
        PRE: begin
          Rx_dv <= 1'b1;
          Rx_er <= 1'b0;
          Rxd   <= lane;
          phase <= next_phase;
          if (advance) begin
            if (cnt == PRE_LAST) begin
              cnt   <= '0;
              state <= SFD;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        SFD: begin
          Rx_dv <= 1'b1;
          Rx_er <= 1'b0;
          Rxd   <= lane;
          phase <= next_phase;
          crc   <= '1;
          if (advance) begin
            cnt   <= '0;
            state <= DATA;
          end
        end
        DATA: begin
          Rx_dv <= 1'b1;
          Rx_er <= err_en_q && (cnt == err_pos_q);
          Rxd   <= lane;
          phase <= next_phase;
          if (advance) begin
            crc <= crc_byte(crc, data_byte);
            if (cnt == len_q - 16'd1) begin
              cnt   <= '0;
              state <= FCS;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        FCS: begin
          Rx_dv <= 1'b1;
          Rx_er <= 1'b0;
          Rxd   <= lane;
          phase <= next_phase;
          if (advance) begin
            if (cnt == 16'd3) begin
              cnt   <= '0;
              state <= IFG;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        IFG: begin
          Rx_dv <= 1'b0;
          Rx_er <= 1'b0;
          Rxd   <= '0;
          if (cnt == IFG_END) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            frm_cnt <= frm_cnt + 16'd1;
            cnt     <= '0;
            phase   <= 1'b0;
            state   <= IDLE;
          end else begin
            phase <= next_phase;
            if (advance) cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mii_frame_gen.sv
// Directed bench for mii_frame_gen: CRC test vector in GMII and MII,
// FCS corruption, Rx_er placement, mid-frame reset and back-to-back frames.
module tb_mii_frame_gen;

  localparam int PRE = 7;
  localparam int IFG = 12;

  logic        Rx_clk;
  logic        reset;
  logic        start;
  logic        mode;
  logic [15:0] frm_len;
  logic [7:0]  seed;
  logic        err_en;
  logic [15:0] err_pos;
  logic        fcs_bad;
  logic        Rx_dv;
  logic        Rx_er;
  logic [7:0]  Rxd;
  logic        busy;
  logic        done;
  logic [15:0] frm_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_cnt  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] fcs_exp [4];
  bit         fcs_known;

  mii_frame_gen #(.PREAMBLE_LEN(PRE), .IFG_LEN(IFG)) dut (
    .Rx_clk  (Rx_clk),
    .reset   (reset),
    .start   (start),
    .mode    (mode),
    .frm_len (frm_len),
    .seed    (seed),
    .err_en  (err_en),
    .err_pos (err_pos),
    .fcs_bad (fcs_bad),
    .Rx_dv   (Rx_dv),
    .Rx_er   (Rx_er),
    .Rxd     (Rxd),
    .busy    (busy),
    .done    (done),
    .frm_cnt (frm_cnt)
  );

  initial Rx_clk = 1'b0;
  always #5 Rx_clk = ~Rx_clk;

  task automatic tick();
    @(posedge Rx_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Bit-serial reference CRC: shift one bit at a time, feedback from bit 0.
  function automatic logic [31:0] crc_bits(input logic [31:0] c, input logic [7:0] b);
    logic fb;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ b[i];
      c  = c >> 1;
      if (fb) c = c ^ 32'hEDB88320;
    end
    return c;
  endfunction

  task automatic run_frame(input string tag, input logic m, input logic [15:0] len,
                           input logic [7:0] sd, input logic ee, input logic [15:0] ep,
                           input logic fb, input bit hold, input int exp_er_cycles);
    logic [7:0]  cap [4];
    logic [7:0]  b;
    logic [31:0] r;
    logic        erx;
    int          dlen;
    int          nb;
    int          er_cnt;
    mode = m; frm_len = len; seed = sd; err_en = ee; err_pos = ep; fcs_bad = fb;
    start = 1'b1;
    tick();
    check({tag, " busy@start"}, busy, 1);
    check({tag, " dv@start"}, Rx_dv, 0);
    if (!hold) start = 1'b0;
    // scrambled inputs must not affect the frame in flight
    mode = ~m; frm_len = 16'd3; seed = ~sd; err_en = ~ee; err_pos = 16'd0; fcs_bad = ~fb;
    dlen = (len == 16'd0) ? 1 : int'(len);
    exp_q.delete();
    for (int i = 0; i < PRE; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < dlen; i++) exp_q.push_back(8'(int'(sd) + i));
    nb = exp_q.size() + 4;
    er_cnt = 0;
    for (int i = 0; i < nb; i++) begin
      b = (i < exp_q.size()) ? exp_q[i] : 8'h00;
      for (int h = 0; h < (m ? 1 : 2); h++) begin
        tick();
        erx = ee && (i >= PRE + 1) && (i < PRE + 1 + dlen) && ((i - PRE - 1) == int'(ep));
        check($sformatf("%s dv byte %0d", tag, i), Rx_dv, 1);
        check($sformatf("%s er byte %0d", tag, i), Rx_er, erx);
        if (Rx_er) er_cnt++;
        if (i < exp_q.size()) begin
          check($sformatf("%s rxd byte %0d.%0d", tag, i, h), Rxd,
                m ? b : (h != 0 ? {4'h0, b[7:4]} : {4'h0, b[3:0]}));
        end else if (m) begin
          cap[i - exp_q.size()] = Rxd;
        end else begin
          check($sformatf("%s fcs hi lane %0d", tag, i), Rxd[7:4], 0);
          if (h == 0) cap[i - exp_q.size()][3:0] = Rxd[3:0];
          else        cap[i - exp_q.size()][7:4] = Rxd[3:0];
        end
      end
    end
    if (fcs_known)
      for (int k = 0; k < 4; k++) check($sformatf("%s fcs%0d", tag, k), cap[k], fcs_exp[k]);
    if (!fb) begin
      r = '1;
      for (int i = 0; i < dlen; i++) r = crc_bits(r, 8'(int'(sd) + i));
      for (int k = 0; k < 4; k++) r = crc_bits(r, cap[k]);
      check({tag, " residue"}, r, 32'hDEBB20E3);
    end
    check({tag, " er cycles"}, er_cnt, exp_er_cycles);
    for (int i = 0; i < (m ? IFG : 2 * IFG); i++) begin
      tick();
      check($sformatf("%s ifg dv %0d", tag, i), Rx_dv, 0);
      check($sformatf("%s ifg rxd %0d", tag, i), Rxd, 0);
      check($sformatf("%s ifg done %0d", tag, i), done, 0);
      check($sformatf("%s ifg busy %0d", tag, i), busy, 1);
    end
    tick();
    exp_cnt++;
    check({tag, " done"}, done, 1);
    check({tag, " busy@done"}, busy, 0);
    check({tag, " frm_cnt"}, frm_cnt, exp_cnt);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mode = 1'b1; frm_len = '0; seed = '0;
    err_en = 1'b0; err_pos = '0; fcs_bad = 1'b0;
    #3;
    check("rst dv", Rx_dv, 0);
    check("rst er", Rx_er, 0);
    check("rst rxd", Rxd, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst frm_cnt", frm_cnt, 0);
    tick(); tick();
    reset = 1'b1;
    tick();
    check("idle busy", busy, 0);

    // "123456789" -> CRC 0xCBF43926, sent LSB first
    fcs_exp[0] = 8'h26; fcs_exp[1] = 8'h39; fcs_exp[2] = 8'hF4; fcs_exp[3] = 8'hCB;
    fcs_known = 1'b1;
    run_frame("gmii_vec", 1'b1, 16'd9, 8'h31, 1'b0, 16'd0, 1'b0, 1'b0, 0);
    tick();
    check("done pulse width", done, 0);

    run_frame("mii_vec", 1'b0, 16'd9, 8'h31, 1'b0, 16'd0, 1'b0, 1'b0, 0);

    fcs_exp[0] = 8'h27;
    run_frame("fcs_bad", 1'b1, 16'd9, 8'h31, 1'b0, 16'd0, 1'b1, 1'b0, 0);

    fcs_known = 1'b0;
    run_frame("err10", 1'b1, 16'd64, 8'h00, 1'b1, 16'd10, 1'b0, 1'b0, 1);
    run_frame("err_oob", 1'b1, 16'd4, 8'hFE, 1'b1, 16'd4, 1'b0, 1'b0, 0);
    run_frame("len0", 1'b1, 16'd0, 8'h80, 1'b1, 16'd0, 1'b0, 1'b0, 1);

    // reset while DATA byte 5 is on Rxd
    mode = 1'b1; frm_len = 16'd9; seed = 8'h31; err_en = 1'b0; fcs_bad = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    check("pre-rst dv", Rx_dv, 1);
    check("pre-rst rxd", Rxd, 8'h36);
    #2 reset = 1'b0;
    #1;
    check("abort dv", Rx_dv, 0);
    check("abort er", Rx_er, 0);
    check("abort rxd", Rxd, 0);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort frm_cnt", frm_cnt, 0);
    tick();
    reset = 1'b1;
    exp_cnt = 0;

    // start held high throughout: three back-to-back frames
    run_frame("b2b1", 1'b1, 16'd1, 8'h40, 1'b0, 16'd0, 1'b0, 1'b1, 0);
    run_frame("b2b2", 1'b1, 16'd1, 8'h41, 1'b0, 16'd0, 1'b0, 1'b1, 0);
    run_frame("b2b3", 1'b1, 16'd1, 8'h42, 1'b0, 16'd0, 1'b0, 1'b1, 0);
    start = 1'b0;
    check("b2b frm_cnt", frm_cnt, 3);
    tick(); tick();
    check("final idle busy", busy, 0);
    check("final idle dv", Rx_dv, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
